// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data memory arbiter.
// Used by dmem_arbiter and dmem_arb_rr_pick.
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} t_arb_state;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    function automatic logic [1:0] port_onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// Combinational 2-way round-robin picker: a lone request wins outright,
// a tie goes to the port that was not granted last.
module dmem_arb_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       sel
);

    assign valid = |req;
    assign sel   = (&req) ? ~last : req[PORT_HOST];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory with req/gnt/rvalid handshake.
// Optional saturating statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_wr,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_wr,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_p0_gnts,
    output logic [15:0]   stat_p1_gnts,
    output logic [15:0]   stat_stall
`endif
);

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    t_arb_state          state_reg;
    logic                last_gnt_reg;
    logic                sel_reg;
    logic                wr_reg;
    logic [1:0]          wait_cnt_reg;
    logic [1:0]          gnt_reg;
    logic [1:0]          rvalid_reg;
    logic                mem_rd_reg;
    logic                mem_wr_reg;
    logic [AW-1:0]       addr_reg;
    logic [DW-1:0]       wdata_reg;
    logic [1:0][DW-1:0]  rdata_reg;

    logic                pick_valid;
    logic                pick_sel;
    logic                capture;

    dmem_arb_rr_pick u_pick (
        .req   ({p1_req, p0_req}),
        .last  (last_gnt_reg),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    // Final WAIT edge: memory data is valid and gets latched for the winner.
    assign capture = (state_reg == WAIT) && (wait_cnt_reg == 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            last_gnt_reg <= PORT_HOST;
            sel_reg      <= PORT_CPU;
            wr_reg       <= 1'b0;
            wait_cnt_reg <= 2'd0;
            gnt_reg      <= 2'b00;
            rvalid_reg   <= 2'b00;
            mem_rd_reg   <= 1'b0;
            mem_wr_reg   <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else begin
            gnt_reg    <= 2'b00;
            rvalid_reg <= 2'b00;
            mem_rd_reg <= 1'b0;
            mem_wr_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        sel_reg      <= pick_sel;
                        last_gnt_reg <= pick_sel;
                        wr_reg       <= pick_sel ? p1_wr : p0_wr;
                        addr_reg     <= pick_sel ? p1_addr : p0_addr;
                        wdata_reg    <= pick_sel ? p1_wdata : p0_wdata;
                        gnt_reg      <= port_onehot(pick_sel);
                        mem_rd_reg   <= pick_sel ? ~p1_wr : ~p0_wr;
                        mem_wr_reg   <= pick_sel ? p1_wr : p0_wr;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wr_reg) begin
                        state_reg <= IDLE;
                    end else begin
                        wait_cnt_reg <= WAIT_INIT;
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (capture) begin
                        rvalid_reg <= port_onehot(sel_reg);
                        state_reg  <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 2'd1;
                    end
                end
                RESP: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rdata_reg[gi] <= '0;
            end else if (capture && sel_reg == 1'(gi)) begin
                rdata_reg[gi] <= mem_rdata;
            end
        end
    end

    assign p0_gnt    = gnt_reg[PORT_CPU];
    assign p1_gnt    = gnt_reg[PORT_HOST];
    assign p0_rvalid = rvalid_reg[PORT_CPU];
    assign p1_rvalid = rvalid_reg[PORT_HOST];
    assign p0_rdata  = rdata_reg[PORT_CPU];
    assign p1_rdata  = rdata_reg[PORT_HOST];
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_rd    = mem_rd_reg;
    assign mem_wr    = mem_wr_reg;
    assign busy      = (state_reg != IDLE);

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_p0_reg;
    logic [15:0] stat_p1_reg;
    logic [15:0] stat_stall_reg;
    logic        stall_now;

    // A cycle stalls when some port asks and is not the one holding gnt right now.
    assign stall_now = (p0_req & ~gnt_reg[PORT_CPU]) | (p1_req & ~gnt_reg[PORT_HOST]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_p0_reg    <= 16'd0;
            stat_p1_reg    <= 16'd0;
            stat_stall_reg <= 16'd0;
        end else begin
            stat_p0_reg    <= sat_inc(stat_p0_reg, gnt_reg[PORT_CPU]);
            stat_p1_reg    <= sat_inc(stat_p1_reg, gnt_reg[PORT_HOST]);
            stat_stall_reg <= sat_inc(stat_stall_reg, stall_now);
        end
    end

    assign stat_p0_gnts = stat_p0_reg;
    assign stat_p1_gnts = stat_p1_reg;
    assign stat_stall   = stat_stall_reg;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, reset-abort and tie sequences,
// and a randomized run against a transaction-level timing model (stats checked when DMEM_ARB_STATS_EN).
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    parameter int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          p0_req = 1'b0, p0_wr = 1'b0, p1_req = 1'b0, p1_wr = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr, busy;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   stat_p0_gnts, stat_p1_gnts, stat_stall;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_STATS_EN
        , .stat_p0_gnts(stat_p0_gnts), .stat_p1_gnts(stat_p1_gnts), .stat_stall(stat_stall)
`endif
    );

    function automatic logic [15:0] init_val(input int a);
        logic [15:0] v;
        v = 16'(a) * 16'h0101 ^ 16'h3C00;
        if (a == 16) v = 16'hBEEF;
        if (a == 5)  v = 16'h00A5;
        return v;
    endfunction

    // Physical memory with an RD_LAT-deep read pipeline; reloaded while reset is low.
    logic [DW-1:0] phys    [256];
    logic [DW-1:0] rd_pipe [RD_LAT];
    assign mem_rdata = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) phys[i] <= init_val(i);
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
        end else begin
            if (mem_wr) phys[mem_addr] <= mem_wdata;
            if (mem_rd) rd_pipe[0] <= phys[mem_addr];
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        logic          port;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } vec_t;

    txn_t q0[$], q1[$];
    int   total = 0, bad = 0;
    int   cyc = 0;

    // Transaction-level model: one outstanding transaction, timed from its sample cycle.
    logic [DW-1:0] model_mem [256];
    int            next_idle, rec_s, stall_m;
    logic          last_m, rec_valid, rec_port, rec_wr;
    logic [AW-1:0] rec_addr;
    logic [DW-1:0] rec_wdata, rec_rdata;
    logic [DW-1:0] exp_rdata [2];
    logic          gnt_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
        next_idle = 0; last_m = 1'b1; rec_valid = 1'b0; rec_s = 0;
        exp_rdata[0] = '0; exp_rdata[1] = '0; stall_m = 0; cyc = 0;
    endtask

    function automatic logic exp_gnt(input logic p);
        return rec_valid && cyc == rec_s + 1 && rec_port == p;
    endfunction

    task automatic model_step();
        logic w;
        if ((p0_req && !exp_gnt(1'b0)) || (p1_req && !exp_gnt(1'b1))) stall_m++;
        if (cyc >= next_idle && (p0_req || p1_req)) begin
            w         = (p0_req && p1_req) ? !last_m : p1_req;
            rec_valid = 1'b1;
            rec_s     = cyc;
            rec_port  = w;
            rec_wr    = w ? p1_wr : p0_wr;
            rec_addr  = w ? p1_addr : p0_addr;
            rec_wdata = w ? p1_wdata : p0_wdata;
            if (rec_wr) model_mem[rec_addr] = rec_wdata;
            else        rec_rdata = model_mem[rec_addr];
            next_idle = cyc + (rec_wr ? 2 : 3 + RD_LAT);
            last_m    = w;
        end
    endtask

    task automatic check_cycle();
        logic       iss, resp, eb;
        logic [1:0] eg, ev;
        iss  = rec_valid && cyc == rec_s + 1;
        resp = rec_valid && !rec_wr && cyc == rec_s + 2 + RD_LAT;
        eg   = iss  ? (rec_port ? 2'b10 : 2'b01) : 2'b00;
        ev   = resp ? (rec_port ? 2'b10 : 2'b01) : 2'b00;
        eb   = rec_valid && cyc > rec_s && cyc < next_idle;
        if (resp) exp_rdata[rec_port] = rec_rdata;
        if (p0_gnt) gnt_log.push_back(1'b0);
        if (p1_gnt) gnt_log.push_back(1'b1);
        chk("gnt", 32'({p1_gnt, p0_gnt}), 32'(eg));
        chk("rvalid", 32'({p1_rvalid, p0_rvalid}), 32'(ev));
        chk("mem_wr_rd", 32'({mem_wr, mem_rd}), 32'({iss && rec_wr, iss && !rec_wr}));
        chk("busy", 32'(busy), 32'(eb));
        chk("p0_rdata", 32'(p0_rdata), 32'(exp_rdata[0]));
        chk("p1_rdata", 32'(p1_rdata), 32'(exp_rdata[1]));
        if (rec_valid && cyc > rec_s && cyc <= rec_s + 1 + (rec_wr ? 0 : RD_LAT))
            chk("mem_addr", 32'(mem_addr), 32'(rec_addr));
        if (iss && rec_wr) chk("mem_wdata", 32'(mem_wdata), 32'(rec_wdata));
    endtask

    task automatic drive();
        if (q0.size() != 0 && p0_gnt) void'(q0.pop_front());
        if (q1.size() != 0 && p1_gnt) void'(q1.pop_front());
        p0_req = (q0.size() != 0);
        p1_req = (q1.size() != 0);
        if (p0_req) begin p0_wr = q0[0].wr; p0_addr = q0[0].addr; p0_wdata = q0[0].wdata; end
        else        begin p0_wr = 1'b0; p0_addr = '0; p0_wdata = '0; end
        if (p1_req) begin p1_wr = q1[0].wr; p1_addr = q1[0].addr; p1_wdata = q1[0].wdata; end
        else        begin p1_wr = 1'b0; p1_addr = '0; p1_wdata = '0; end
    endtask

    task automatic go();
        drive();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        do begin
            go();
            n++;
        end while ((q0.size() != 0 || q1.size() != 0 || busy) && n < budget);
        total++;
        if (q0.size() != 0 || q1.size() != 0 || busy) begin
            bad++;
            $display("FAIL timeout cyc=%0d got=busy_or_pending want=idle", cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        q0.delete(); q1.delete();
        p0_req = 0; p1_req = 0; p0_wr = 0; p1_wr = 0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", {p1_rdata, p0_rdata}, 32'd0);
        chk("rst_ctl", 32'({p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_rd, mem_wr, busy, mem_addr}), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
`ifdef DMEM_ARB_STATS_EN
        chk("rst_stats", 32'({stat_p0_gnts, stat_p1_gnts} | 32'(stat_stall)), 32'd0);
`endif
        rst = 1'b1;
        model_reset();
    endtask

    function automatic txn_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.wr = wr; t.addr = a; t.wdata = d;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        vt[0] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
        vt[1] = '{1'b1, 1'b1, 8'h22, 16'h1234, 16'h0000};
        vt[2] = '{1'b1, 1'b0, 8'h22, 16'h0000, 16'h1234};
        vt[3] = '{1'b0, 1'b0, 8'h05, 16'h0000, 16'h00A5};
        vt[4] = '{1'b0, 1'b1, 8'h05, 16'h5A5A, 16'h0000};
        vt[5] = '{1'b1, 1'b0, 8'h05, 16'h0000, 16'h5A5A};
        vt[6] = '{1'b0, 1'b0, 8'h03, 16'h0000, 16'h3F03};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (vt[i].port) q1.push_back(mk(vt[i].wr, vt[i].addr, vt[i].wdata));
            else            q0.push_back(mk(vt[i].wr, vt[i].addr, vt[i].wdata));
            run_idle(40);
            if (!vt[i].wr)
                chk("vec_rdata", 32'(vt[i].port ? p1_rdata : p0_rdata), 32'(vt[i].rdata));
            $display("vec %0d port=%0d wr=%0d addr=%h p0_rdata=%h p1_rdata=%h",
                     i, vt[i].port, vt[i].wr, vt[i].addr, p0_rdata, p1_rdata);
        end

        // Both ports contend for four reads: grants must alternate starting at port 0.
        do_reset();
        gnt_log.delete();
        q0.push_back(mk(1'b0, 8'h10, 16'h0)); q0.push_back(mk(1'b0, 8'h03, 16'h0));
        q1.push_back(mk(1'b0, 8'h05, 16'h0)); q1.push_back(mk(1'b0, 8'h22, 16'h0));
        run_idle(60);
        chk("tie_count", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < gnt_log.size() && i < 4; i++)
            chk("tie_order", 32'(gnt_log[i]), 32'(i % 2));
        $display("tie p0_rdata=%h p1_rdata=%h grants=%0d", p0_rdata, p1_rdata, gnt_log.size());

        // Reset lands in WAIT of a port 0 read: the read must vanish.
        q0.push_back(mk(1'b0, 8'h10, 16'h0));
        go(); go();
        chk("abort_in_wait", 32'(busy), 32'(1));
        rst = 1'b0;
        #1;
        chk("abort_rdata", 32'(p0_rdata), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("abort_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
        end
        do_reset();
        q0.push_back(mk(1'b0, 8'h10, 16'h0));
        run_idle(40);
        chk("after_abort", 32'(p0_rdata), 32'hBEEF);
        $display("abort p0_rdata=%h", p0_rdata);

        // Randomized traffic on both ports.
        for (int i = 0; i < 600; i++) begin
            if (q0.size() < 2 && $urandom_range(3) == 0)
                q0.push_back(mk(1'($urandom_range(1)), 8'($urandom_range(7)), 16'($urandom)));
            if (q1.size() < 2 && $urandom_range(3) == 0)
                q1.push_back(mk(1'($urandom_range(1)), 8'($urandom_range(7)), 16'($urandom)));
            go();
        end
        run_idle(100);
        $display("random cycles=%0d total=%0d", cyc, total);

`ifdef DMEM_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) q0.push_back(mk(1'b1, 8'(8'h40 + i), 16'(16'h1000 + i)));
        go(); go();
        q1.push_back(mk(1'b1, 8'h50, 16'hAAAA)); q1.push_back(mk(1'b1, 8'h51, 16'hBBBB));
        run_idle(60);
        chk("stat_p0_gnts", 32'(stat_p0_gnts), 32'd3);
        chk("stat_p1_gnts", 32'(stat_p1_gnts), 32'd2);
        chk("stat_stall", 32'(stat_stall), 32'(stall_m));
        $display("stats p0=%0d p1=%0d stall=%0d model_stall=%0d",
                 stat_p0_gnts, stat_p1_gnts, stat_stall, stall_m);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
